mio_bus_bridge: RTL
===================

Name: mio_bus_bridge

Overview:
- Memory/IO bus bridge directly downstream of the multicycle CPU controller.
- Takes the controller's memory request strobes and the byte/half/word size code, then runs a synchronous RAM access or a peripheral IO access.
- Returns the MIO_ready handshake and the load data, aligned and sign/zero-extended.
- Generates RAM byte-lane write enables and lane-replicated write data.

Parameters:
- RAM_AW, 12, RAM word-address width; ram_addr = cpu_addr[RAM_AW+1:2].
- RAM_LAT, 1, RAM read latency in cycles (1..7).
- IO_NIB, 4'hF, cpu_addr[31:28] value that selects the IO space; any other value selects RAM.
- TIMEOUT_CYC, 16, number of IO_WAIT cycles allowed without io_ack (used only with MIO_TIMEOUT_EN).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- cpu_mem_r  in  1  read request (controller MemRead)
- cpu_mem_w  in  1  write request (controller MemWrite)
- cpu_mio  in  1  request qualifier (controller CPU_MIO)
- cpu_size  in  2  00 word, 01 half, 10 byte, 11 treated as word (controller Din/Dout size code)
- cpu_signed  in  1  1 = sign-extend half/byte loads
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  store data, right-justified
- mio_ready  out  1  one-cycle completion pulse
- cpu_rdata  out  32  aligned, extended load data; held until the next accept
- bus_err  out  1  pulses together with mio_ready on a misaligned access or an IO timeout
- ram_en  out  1  RAM enable
- ram_we  out  4  RAM byte-lane write enables
- ram_addr  out  RAM_AW  RAM word address
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data
- io_rd  out  1  IO read strobe
- io_wr  out  1  IO write strobe
- io_addr  out  32  IO byte address
- io_wdata  out  32  IO write data, unreplicated
- io_rdata  in  32  IO read data
- io_ack  in  1  IO completion

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; wait counter 0.
- FSM states: IDLE, RAM_WAIT, IO_WAIT, DONE.
- Transaction accept: in IDLE, a transaction is accepted when cpu_mio & (cpu_mem_r | cpu_mem_w) is high.
  - On accept, register address, size, signed flag, write data and direction.
  - If cpu_mem_r and cpu_mem_w are both high, the access is a write.
- Misaligned access: word with addr[1:0]!=0, or half with addr[0]=1.
  - Go IDLE->DONE directly; no RAM or IO strobe is issued.
  - In DONE: bus_err=1, cpu_rdata=0.
- RAM access (addr[31:28]!=IO_NIB): IDLE->RAM_WAIT.
  - RAM_WAIT lasts RAM_LAT+1 cycles.
  - ram_en=1 and ram_we are driven only in the first RAM_WAIT cycle; ram_we=0 for reads.
  - For reads, ram_rdata is captured on the edge ending the last RAM_WAIT cycle; then go to DONE.
- IO access (addr[31:28]==IO_NIB): IDLE->IO_WAIT.
  - io_rd or io_wr is held high until io_ack is sampled high.
  - On that edge, capture io_rdata (reads) and go to DONE.
  - io_ack seen while in IDLE is ignored.
- DONE: lasts one cycle with mio_ready=1, then unconditionally returns to IDLE. A request still asserted in IDLE is accepted as a new transaction, so back-to-back requests cost one IDLE cycle between them.
- Write lanes:
  - byte: ram_wdata={4{wdata[7:0]}}, ram_we=4'b0001<<addr[1:0].
  - half: ram_wdata={2{wdata[15:0]}}, ram_we = addr[1] ? 4'b1100 : 4'b0011.
  - word: wdata as-is, ram_we=4'b1111.
- Read alignment:
  - half selects lane addr[1]; byte selects lane addr[1:0].
  - The selected lane is sign-extended if cpu_signed=1, else zero-extended. Word data is passed through unchanged.
  - Alignment is applied at capture; cpu_rdata is stable from DONE until the next capture.
- Writes do not modify cpu_rdata.
- Reset mid-transaction: the FSM immediately returns to IDLE, all strobes drop, and the pending access is abandoned with no mio_ready.
- Latency with RAM_LAT=1: request seen at cycle T -> ram_en at T+1 -> mio_ready at T+3.

Optional Feature:
- Macro: MIO_TIMEOUT_EN.
- Defined: a counter runs in IO_WAIT. If TIMEOUT_CYC cycles elapse without io_ack:
  - strobes drop and the FSM goes to DONE;
  - bus_err=1, and cpu_rdata=32'hFFFF_FFFF if the access was a read.
  - The counter clears on every accept.
- Not defined: IO_WAIT waits for io_ack indefinitely, and bus_err is driven only by misalignment.

Test Plan:
- RAM word read, addr 0x0000_0010, ram_rdata=0x8765_4321, RAM_LAT=1 -> ram_en at T+1 with ram_addr=4, mio_ready at T+3, cpu_rdata=0x8765_4321, bus_err=0.
- Signed byte load, addr 0x13, ram_rdata=0x80xx_xxxx -> cpu_rdata=0xFFFF_FF80; the same access with cpu_signed=0 -> 0x0000_0080.
- Half store, addr 0x22, wdata=0x0000_BEEF -> ram_we=4'b1100, ram_wdata=0xBEEF_BEEF, exactly one ram_en cycle, mio_ready 2 cycles later.
- Misaligned word read, addr 0x06 -> no ram_en, no io_rd, mio_ready and bus_err at T+1, cpu_rdata=0.
- IO read, addr 0xF000_0004, io_ack raised after 5 cycles with io_rdata=0x1234 -> io_rd high for 5 cycles, then mio_ready=1, cpu_rdata=0x1234.
  - With MIO_TIMEOUT_EN and no io_ack -> after 16 cycles bus_err=1, cpu_rdata=0xFFFF_FFFF.
- Reset asserted during RAM_WAIT -> all outputs 0 asynchronously, no mio_ready; the next request completes normally.

Source files
------------

// File: rtl/mio_bus_bridge.sv
// Memory/IO bus bridge: turns controller MemRead/MemWrite strobes into sync-RAM or IO-port accesses.
// Optional IO-wait timeout is compiled in with `define MIO_TIMEOUT_EN.
module mio_bus_bridge #(
    parameter int         RAM_AW      = 12,
    parameter int         RAM_LAT     = 1,
    parameter logic [3:0] IO_NIB      = 4'hF,
    parameter int         TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_mem_r,
    input  logic              cpu_mem_w,
    input  logic              cpu_mio,
    input  logic [1:0]        cpu_size,
    input  logic              cpu_signed,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              mio_ready,
    output logic [31:0]       cpu_rdata,
    output logic              bus_err,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic              io_rd,
    output logic              io_wr,
    output logic [31:0]       io_addr,
    output logic [31:0]       io_wdata,
    input  logic [31:0]       io_rdata,
    input  logic              io_ack
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + RAM_LAT + 2);
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(RAM_LAT);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RAM_WAIT = 2'd1,
        IO_WAIT  = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t            state_r;
    state_t            next_state_s;
    logic [CNT_W-1:0]  wait_cnt_r;
    logic              write_r;
    logic [1:0]        size_r;
    logic              signed_r;
    logic [1:0]        addr_lo_r;

    logic              accept_s;
    logic              misalign_s;
    logic              is_io_s;
    logic              ram_last_s;
    logic              timeout_s;
    logic              cnt_io_s;
    logic              go_ram_s;
    logic              go_io_s;
    logic              ram_en_s;
    logic [3:0]        ram_we_s;
    logic              io_rd_s;
    logic              io_wr_s;
    logic              mio_ready_s;
    logic              bus_err_s;
    logic [31:0]       rdata_next_s;

    // Size code 11 behaves as a word everywhere.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'b01:   is_misaligned = lo[0];
            2'b10:   is_misaligned = 1'b0;
            default: is_misaligned = (lo != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] lane_we(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'b10:   lane_we = 4'b0001 << lo;
            2'b01:   lane_we = lo[1] ? 4'b1100 : 4'b0011;
            default: lane_we = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            2'b10:   lane_wdata = {4{wd[7:0]}};
            2'b01:   lane_wdata = {2{wd[15:0]}};
            default: lane_wdata = wd;
        endcase
    endfunction

    function automatic logic [31:0] align_load(input logic [1:0] size, input logic sgn,
                                               input logic [1:0] lo, input logic [31:0] raw);
        logic [15:0] half_v;
        logic [7:0]  byte_v;
        half_v = lo[1] ? raw[31:16] : raw[15:0];
        case (lo)
            2'b00:   byte_v = raw[7:0];
            2'b01:   byte_v = raw[15:8];
            2'b10:   byte_v = raw[23:16];
            default: byte_v = raw[31:24];
        endcase
        case (size)
            2'b01:   align_load = {{16{sgn & half_v[15]}}, half_v};
            2'b10:   align_load = {{24{sgn & byte_v[7]}}, byte_v};
            default: align_load = raw;
        endcase
    endfunction

    assign accept_s   = (state_r == IDLE) && cpu_mio && (cpu_mem_r || cpu_mem_w);
    assign misalign_s = is_misaligned(cpu_size, cpu_addr[1:0]);
    assign is_io_s    = (cpu_addr[31:28] == IO_NIB);
    assign ram_last_s = (wait_cnt_r == LAT_LAST);

`ifdef MIO_TIMEOUT_EN
    assign cnt_io_s  = (state_r == IO_WAIT);
    assign timeout_s = (state_r == IO_WAIT) && (wait_cnt_r == TO_LAST);
`else
    assign cnt_io_s  = 1'b0;
    assign timeout_s = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s && misalign_s) begin
                    next_state_s = DONE;
                end else if (accept_s && is_io_s) begin
                    next_state_s = IO_WAIT;
                end else if (accept_s) begin
                    next_state_s = RAM_WAIT;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RAM_WAIT: begin
                if (ram_last_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = RAM_WAIT;
                end
            end
            IO_WAIT: begin
                if (io_ack || timeout_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = IO_WAIT;
                end
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Output logic: values the output registers take for the cycle being entered
    always_comb begin
        ram_en_s     = 1'b0;
        ram_we_s     = 4'b0000;
        io_rd_s      = 1'b0;
        io_wr_s      = 1'b0;
        mio_ready_s  = 1'b0;
        bus_err_s    = 1'b0;
        go_ram_s     = 1'b0;
        go_io_s      = 1'b0;
        rdata_next_s = cpu_rdata;
        case (state_r)
            IDLE: begin
                if (accept_s && misalign_s) begin
                    mio_ready_s  = 1'b1;
                    bus_err_s    = 1'b1;
                    rdata_next_s = 32'h0000_0000;
                end else if (accept_s && is_io_s) begin
                    go_io_s = 1'b1;
                    io_rd_s = ~cpu_mem_w;
                    io_wr_s = cpu_mem_w;
                end else if (accept_s) begin
                    go_ram_s = 1'b1;
                    ram_en_s = 1'b1;
                    ram_we_s = cpu_mem_w ? lane_we(cpu_size, cpu_addr[1:0]) : 4'b0000;
                end else begin
                    rdata_next_s = cpu_rdata;
                end
            end
            RAM_WAIT: begin
                if (ram_last_s) begin
                    mio_ready_s  = 1'b1;
                    rdata_next_s = write_r ? cpu_rdata
                                           : align_load(size_r, signed_r, addr_lo_r, ram_rdata);
                end else begin
                    rdata_next_s = cpu_rdata;
                end
            end
            IO_WAIT: begin
                if (io_ack) begin
                    mio_ready_s  = 1'b1;
                    rdata_next_s = write_r ? cpu_rdata
                                           : align_load(size_r, signed_r, addr_lo_r, io_rdata);
                end else if (timeout_s) begin
                    mio_ready_s  = 1'b1;
                    bus_err_s    = 1'b1;
                    rdata_next_s = write_r ? cpu_rdata : 32'hFFFF_FFFF;
                end else begin
                    io_rd_s = ~write_r;
                    io_wr_s = write_r;
                end
            end
            DONE:    rdata_next_s = cpu_rdata;
            default: rdata_next_s = cpu_rdata;
        endcase
    end

    // Wait counter: RAM latency in RAM_WAIT, IO timeout in IO_WAIT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_r <= '0;
        end else if (accept_s) begin
            wait_cnt_r <= '0;
        end else if ((state_r == RAM_WAIT) || cnt_io_s) begin
            wait_cnt_r <= wait_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Transaction attributes needed when the load data is captured
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_r   <= 1'b0;
            size_r    <= 2'b00;
            signed_r  <= 1'b0;
            addr_lo_r <= 2'b00;
        end else if (accept_s) begin
            write_r   <= cpu_mem_w;
            size_r    <= cpu_size;
            signed_r  <= cpu_signed;
            addr_lo_r <= cpu_addr[1:0];
        end
    end

    // Output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_en    <= 1'b0;
            ram_we    <= 4'b0000;
            io_rd     <= 1'b0;
            io_wr     <= 1'b0;
            mio_ready <= 1'b0;
            bus_err   <= 1'b0;
            cpu_rdata <= 32'h0000_0000;
            ram_addr  <= '0;
            ram_wdata <= 32'h0000_0000;
            io_addr   <= 32'h0000_0000;
            io_wdata  <= 32'h0000_0000;
        end else begin
            ram_en    <= ram_en_s;
            ram_we    <= ram_we_s;
            io_rd     <= io_rd_s;
            io_wr     <= io_wr_s;
            mio_ready <= mio_ready_s;
            bus_err   <= bus_err_s;
            cpu_rdata <= rdata_next_s;
            if (go_ram_s) begin
                ram_addr  <= cpu_addr[RAM_AW+1:2];
                ram_wdata <= lane_wdata(cpu_size, cpu_wdata);
            end
            if (go_io_s) begin
                io_addr  <= cpu_addr;
                io_wdata <= cpu_wdata;
            end
        end
    end

endmodule
